// File: rtl/tt_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tt_sar_adc_ctrl
// Brief    : Successive-approximation ADC sequencer. Runs the sample switch,
//            the DAC trial code and the comparator-bit decisions, MSB first.
// Revision : 1.0  initial release
// ============================================================================
module tt_sar_adc_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SAMPLE = 4,
    parameter int SETTLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overrun
);

    localparam int c_CNT_MAX = (SAMPLE > SETTLE) ? SAMPLE : SETTLE;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = $clog2(WIDTH);

    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(SAMPLE - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE - 1);
    localparam logic [c_IDX_W-1:0] c_MSB_IDX     = c_IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_bit_idx;
    logic                r_cmp_meta;
    logic                r_cmp_s;
    logic [WIDTH-1:0]    w_kept_code;
    logic [WIDTH-1:0]    w_next_trial;

    // Decision on the current bit, and the trial code for the next lower bit.
    always_comb begin
        w_kept_code = dac_code;
        if (!r_cmp_s) begin
            w_kept_code[r_bit_idx] = 1'b0;
        end
        w_next_trial = w_kept_code;
        if (r_bit_idx != '0) begin
            w_next_trial[r_bit_idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_cmp_meta <= 1'b0;
            r_cmp_s    <= 1'b0;
            sample_en  <= 1'b0;
            dac_code   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            overrun    <= 1'b0;
        end else begin
            r_cmp_meta <= cmp_in;
            r_cmp_s    <= r_cmp_meta;
            done       <= 1'b0;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    dac_code <= '0;
                    if (start) begin
                        r_state   <= ST_SAMPLE;
                        overrun   <= 1'b0;
                        sample_en <= 1'b1;
                        busy      <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_SAMPLE: begin
                    if (start) overrun <= 1'b1;
                    if (r_cnt == c_SAMPLE_LAST) begin
                        r_state   <= ST_SETTLE;
                        sample_en <= 1'b0;
                        r_bit_idx <= c_MSB_IDX;
                        dac_code  <= c_MSB_CODE;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (start) overrun <= 1'b1;
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_state <= ST_DECIDE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DECIDE: begin
                    if (start) overrun <= 1'b1;
                    if (r_bit_idx != '0) begin
                        dac_code  <= w_next_trial;
                        r_bit_idx <= r_bit_idx - 1'b1;
                        r_state   <= ST_SETTLE;
                    end else begin
                        dac_code <= w_kept_code;
                        result   <= w_kept_code;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    sample_en <= 1'b0;
                    busy      <= 1'b0;
                    dac_code  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_sar_adc_ctrl
// Brief    : Scoreboard bench for tt_sar_adc_ctrl with an ideal comparator.
// Revision : 1.0  initial release
// ============================================================================
module tb_tt_sar_adc_ctrl;

    localparam int c_LAT = 36;  // posedges from start-sampling edge to DONE entry

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] vin = 8'h00;
    logic       cmp_in;
    logic       sample_en;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       overrun;

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t       q_exp[$];
    logic [7:0] q_trace[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         sample_cnt = 0;
    logic       trace_en = 1'b0;
    logic [7:0] prev_code = 8'h00;

    assign cmp_in = (vin >= dac_code);

    tt_sar_adc_ctrl #(.WIDTH(8), .SAMPLE(4), .SETTLE(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cmp_in    (cmp_in),
        .sample_en (sample_en),
        .dac_code  (dac_code),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst) begin
            sample_cnt = 0;
        end else begin
            if (sample_en) sample_cnt++;
            if (busy && done) chk("busy_and_done", 1, 0);
            if (trace_en && busy && !sample_en && dac_code != prev_code)
                q_trace.push_back(dac_code);
            if (done) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    chk("result", {24'd0, result}, {24'd0, e.res});
                    chk("done_cycle", cyc, e.cyc);
                    chk("sample_cycles", sample_cnt, 4);
                end
                sample_cnt = 0;
            end
        end
        prev_code = dac_code;
    end

    // Pulse start for one cycle and record the expected completion.
    task automatic do_start(input logic [7:0] v);
        @(negedge clk);
        vin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        q_exp.push_back('{res: v, cyc: cyc + c_LAT});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (q_exp.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q_exp.size() != 0) begin
            chk("timeout", 1, 0);
            q_exp.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sample_en"}, sample_en, 0);
        chk({tag, "_dac_code"}, dac_code, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        logic [7:0] exp_trace[8];
        int         n_done;

        exp_trace = '{8'h80, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        // Single conversions, including both rails.
        do_start(8'hA5);
        wait_empty(100);
        chk("overrun_idle", overrun, 0);
        do_start(8'h00);
        wait_empty(100);
        do_start(8'hFF);
        wait_empty(100);

        // Start while busy is ignored but flagged until the next accepted start.
        do_start(8'h5A);
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty(100);
        chk("overrun_set", overrun, 1);
        do_start(8'h33);
        chk("overrun_clear", overrun, 0);
        wait_empty(100);

        // Start held high: back-to-back conversions with no idle gap.
        @(negedge clk);
        vin   = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            q_exp.push_back('{res: 8'h3C, cyc: cyc + c_LAT + k * (c_LAT + 1)});
        n_done = 0;
        for (int n = 0; n < 200 && n_done < 3; n++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        start = 1'b0;
        wait_empty(50);

        // Reset mid-conversion: outputs cleared, no done, result lost.
        do_start(8'hA5);
        q_exp.delete();
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_done_result", result, 0);
        do_start(8'h81);
        wait_empty(100);

        // Per-bit trial-code trace.
        q_trace.delete();
        trace_en = 1'b1;
        do_start(8'h80);
        wait_empty(100);
        trace_en = 1'b0;
        chk("trace_len", q_trace.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < q_trace.size()) chk($sformatf("trace_%0d", k), q_trace[k], exp_trace[k]);
        end
        chk("final_dac_code_idle", dac_code, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
